// File: rtl/alu_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// alu_mc - multi-cycle ALU: 1-cycle simple ops, iterative MUL/DIV  | rev 1.0
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH    = 32,
  parameter int SHW      = $clog2(WIDTH),
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int               W2       = 2 * WIDTH;
  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / MUL_STEP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             bsgn_q, bsgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             spec_q, spec_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_simple;
  logic             w_a_sext;
  logic             w_div_signed;
  logic             w_want_quo;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_spec_val;
  logic [W2-1:0]    w_mul_acc;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic             w_res_ld;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign result    = result_q;
  assign zero      = zero_q;

  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (op >= OP_MUL) && (op <= OP_MULHU);
  assign w_is_div = (op >= OP_DIV) && (op <= OP_REMU);
  assign w_shamt  = b[SHW-1:0];

  always_comb begin
    w_simple = '0;
    case (op)
      OP_ADD:  w_simple = a + b;
      OP_SUB:  w_simple = a + ~b + WIDTH'(1);
      OP_AND:  w_simple = a & b;
      OP_OR:   w_simple = a | b;
      OP_XOR:  w_simple = a ^ b;
      OP_SLL:  w_simple = a << w_shamt;
      OP_SRL:  w_simple = a >> w_shamt;
      OP_SRA:  w_simple = $unsigned($signed(a) >>> w_shamt);
      OP_SLT:  w_simple[0] = $signed(a) < $signed(b);
      OP_SLTU: w_simple[0] = a < b;
      default: w_simple = '0;
    endcase
  end

  // Operand conditioning at accept: magnitudes for the divider, and the
  // one-shot answers for divide-by-zero and signed overflow.
  assign w_a_sext     = (op == OP_MULH) || (op == OP_MULHSU);
  assign w_div_signed = (op == OP_DIV) || (op == OP_REM);
  assign w_want_quo   = (op == OP_DIV) || (op == OP_DIVU);
  assign w_a_abs      = (w_div_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_b_abs      = (w_div_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign w_div_zero   = (b == '0);
  assign w_div_ovf    = w_div_signed && (a == MIN_NEG) && (b == '1);

  always_comb begin
    w_spec_val = '0;
    if (w_div_zero)     w_spec_val = w_want_quo ? '1 : a;
    else if (w_div_ovf) w_spec_val = w_want_quo ? a : '0;
  end

  // A signed multiplier's top bit carries negative weight, so it subtracts.
  always_comb begin
    w_mul_acc = acc_q;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) begin
        if (bsgn_q && (cnt_q == MUL_LAST) && (j == MUL_STEP - 1))
          w_mul_acc = w_mul_acc - (mcand_q << j);
        else
          w_mul_acc = w_mul_acc + (mcand_q << j);
      end
    end
  end

  assign w_div_sh   = {rem_q, quo_q[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, dvs_q};
  assign w_div_ge   = ~w_div_diff[WIDTH];
  assign w_rem_nx   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
  assign w_quo_nx   = {quo_q[WIDTH-2:0], w_div_ge};
  assign w_quo_fin  = qneg_q ? (~w_quo_nx + WIDTH'(1)) : w_quo_nx;
  assign w_rem_fin  = rneg_q ? (~w_rem_nx + WIDTH'(1)) : w_rem_nx;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    bsgn_d   = bsgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    spec_d   = spec_q;
    result_d = result_q;
    zero_d   = zero_q;
    w_res_ld = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          op_d  = op;
          cnt_d = '0;
          if (w_is_mul) begin
            state_d  = S_MUL;
            mcand_d  = w_a_sext ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            bsgn_d   = (op == OP_MULH);
          end else if (w_is_div) begin
            state_d = S_DIV;
            spec_d  = w_div_zero || w_div_ovf;
            rem_d   = '0;
            quo_d   = (w_div_zero || w_div_ovf) ? w_spec_val : w_a_abs;
            dvs_d   = w_b_abs;
            qneg_d  = w_div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = w_div_signed && a[WIDTH-1];
          end else begin
            state_d  = S_DONE;
            result_d = w_simple;
            w_res_ld = 1'b1;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = w_mul_acc;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          state_d  = S_DONE;
          result_d = (op_q == OP_MUL) ? w_mul_acc[WIDTH-1:0] : w_mul_acc[W2-1:WIDTH];
          w_res_ld = 1'b1;
        end
      end
      S_DIV: begin
        if (spec_q) begin
          state_d  = S_DONE;
          result_d = quo_q;
          w_res_ld = 1'b1;
        end else begin
          rem_d = w_rem_nx;
          quo_d = w_quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DIV_LAST) begin
            state_d  = S_DONE;
            result_d = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? w_quo_fin : w_rem_fin;
            w_res_ld = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_res_ld) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      bsgn_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      bsgn_q   <= bsgn_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule
`default_nettype wire
